// File: rtl/skolem_pkg.sv
// Shared types and helpers for the Skolem witness search block.
// Holds the controller state encoding, the Gray encoder and the terminal-count helper.
package skolem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP
    } state_t;

    localparam int unsigned MAX_Y = 32;

    // Operates at the widest supported y; callers truncate to N_Y bits.
    function automatic logic [MAX_Y-1:0] gray_enc(input logic [MAX_Y-1:0] v);
        return v ^ (v >> 1);
    endfunction

    function automatic int unsigned last_cand(input int unsigned n_y);
        return (32'd1 << n_y) - 32'd1;
    endfunction

endpackage

// File: rtl/skolem_cand_enum.sv
// Candidate enumerator: candidate counter, per-candidate wait counter and registered y.
// Build option SKOLEM_GRAY_ENUM_EN switches y from binary order to Gray order.
module skolem_cand_enum
    import skolem_pkg::*;
#(
    parameter int N_Y      = 5,
    parameter int EVAL_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           run,
    input  logic           adv,
    output logic [N_Y-1:0] cnt,
    output logic [N_Y-1:0] cand_y,
    output logic           last,
    output logic           sample
);

    localparam int WW = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
    localparam logic [N_Y-1:0] LAST_CNT  = N_Y'(last_cand(N_Y));
    localparam logic [WW-1:0]  LAST_WAIT = WW'(EVAL_LAT - 1);

    logic [N_Y-1:0] cnt_q;
    logic [N_Y-1:0] y_q;
    logic [WW-1:0]  wait_q;
    logic [N_Y-1:0] next_cnt;
    logic [N_Y-1:0] next_y;

    assign next_cnt = cnt_q + N_Y'(1);

`ifdef SKOLEM_GRAY_ENUM_EN
    assign next_y = N_Y'(gray_enc(MAX_Y'(next_cnt)));
`else
    assign next_y = next_cnt;
`endif

    // y is registered alongside cnt so the formula sees a clean value from the first edge of each candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            y_q    <= '0;
            wait_q <= '0;
        end else if (clr) begin
            cnt_q  <= '0;
            y_q    <= '0;
            wait_q <= '0;
        end else if (adv) begin
            cnt_q  <= next_cnt;
            y_q    <= next_y;
            wait_q <= '0;
        end else if (run && !sample) begin
            wait_q <= wait_q + WW'(1);
        end
    end

    assign sample = (wait_q == LAST_WAIT);
    assign last   = (cnt_q == LAST_CNT);
    assign cnt    = cnt_q;
    assign cand_y = y_q;

endmodule

// File: rtl/skolem_witness_search.sv
// Searches the existential vector y for the first value satisfying an external formula for a given x.
// Enumeration order is binary by default, Gray when SKOLEM_GRAY_ENUM_EN is defined.
module skolem_witness_search
    import skolem_pkg::*;
#(
    parameter int N_X      = 32,
    parameter int N_Y      = 5,
    parameter int EVAL_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [N_X-1:0] req_x,
    output logic [N_X-1:0] fml_x,
    output logic [N_Y-1:0] fml_y,
    input  logic           fml_sat,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_found,
    output logic [N_Y-1:0] rsp_y,
    output logic [N_Y:0]   rsp_iters
);

    state_t         state_q, state_d;
    logic           clr, run, adv, load;
    logic [N_Y-1:0] cnt, cand_y;
    logic           last, sample;

    skolem_cand_enum #(
        .N_Y      (N_Y),
        .EVAL_LAT (EVAL_LAT)
    ) u_enum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .run    (run),
        .adv    (adv),
        .cnt    (cnt),
        .cand_y (cand_y),
        .last   (last),
        .sample (sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A hit on the terminal candidate is a find, so the sat test precedes the exhaustion test.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        run     = 1'b0;
        adv     = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    clr     = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                run = 1'b1;
                if (sample) begin
                    if (fml_sat || last) begin
                        load    = 1'b1;
                        state_d = RESP;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign fml_y     = cand_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fml_x     <= '0;
            rsp_found <= 1'b0;
            rsp_y     <= '0;
            rsp_iters <= '0;
        end else begin
            if (clr) fml_x <= req_x;
            if (load) begin
                rsp_found <= fml_sat;
                rsp_y     <= fml_sat ? cand_y : '0;
                rsp_iters <= {1'b0, cnt} + (N_Y + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_skolem_witness_search.sv
// Directed testbench for skolem_witness_search with an in-bench formula (y == x[4:0], tied 0 or tied 1).
// Expected values adapt when SKOLEM_GRAY_ENUM_EN is defined.
module tb_skolem_witness_search;

    logic        clk, rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_found, fml_sat;
    logic [31:0] req_x, fml_x;
    logic [4:0]  fml_y, rsp_y;
    logic [5:0]  rsp_iters;

    logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_found3, fml_sat3;
    logic [31:0] req_x3, fml_x3;
    logic [4:0]  fml_y3, rsp_y3;
    logic [5:0]  rsp_iters3;

    int fmode, fmode3;
    int num_checks = 0;
    int num_errors = 0;

`ifdef SKOLEM_GRAY_ENUM_EN
    localparam int          ITERS_13 = 30;
    localparam logic [31:0] X_TERM   = 32'h10;
    localparam int          Y_TERM   = 16;
`else
    localparam int          ITERS_13 = 20;
    localparam logic [31:0] X_TERM   = 32'h1F;
    localparam int          Y_TERM   = 31;
`endif

    assign fml_sat  = (fmode == 0)  ? (fml_y == fml_x[4:0])   : (fmode == 2);
    assign fml_sat3 = (fmode3 == 0) ? (fml_y3 == fml_x3[4:0]) : (fmode3 == 2);

    skolem_witness_search dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
        .fml_x(fml_x), .fml_y(fml_y), .fml_sat(fml_sat), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_found(rsp_found), .rsp_y(rsp_y), .rsp_iters(rsp_iters)
    );

    skolem_witness_search #(.N_X(32), .N_Y(5), .EVAL_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3), .req_x(req_x3),
        .fml_x(fml_x3), .fml_y(fml_y3), .fml_sat(fml_sat3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_found(rsp_found3), .rsp_y(rsp_y3), .rsp_iters(rsp_iters3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [4:0] enc(input int c);
        logic [4:0] t;
        t = 5'(c);
`ifdef SKOLEM_GRAY_ENUM_EN
        return t ^ (t >> 1);
`else
        return t;
`endif
    endfunction

    // Called #1 after an edge with the DUT idle; returns cycles from acceptance edge to rsp_valid.
    task automatic applyStimulus(input logic [31:0] x, input int mode, input bit chk_y, output int cycles);
        logic [4:0] prev;
        fmode     = mode;
        req_x     = x;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_x     = ~x;
        checkOutput("fml_x_latched", fml_x, x);
        cycles = 0;
        prev   = fml_y;
        while (!rsp_valid && cycles < 200) begin
            if (chk_y) begin
                checkOutput("fml_y_seq", fml_y, enc(cycles));
`ifdef SKOLEM_GRAY_ENUM_EN
                if (cycles > 0) checkOutput("gray_step", $countones(prev ^ fml_y), 1);
`endif
            end
            prev = fml_y;
            @(posedge clk); #1;
            cycles++;
        end
        if (!rsp_valid) checkOutput("rsp_timeout", 0, 1);
    endtask

    task automatic applyStimulus3(input int mode, output int cycles);
        fmode3     = mode;
        req_x3     = 32'h0;
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        cycles = 0;
        while (!rsp_valid3 && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!rsp_valid3) checkOutput("rsp3_timeout", 0, 1);
    endtask

    task automatic finishResp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput("hs_rsp_valid", rsp_valid, 0);
        checkOutput("hs_req_ready", req_ready, 1);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; req_valid = 1'b0; req_x = '0; rsp_ready = 1'b0; fmode = 1;
        req_valid3 = 1'b0; req_x3 = '0; rsp_ready3 = 1'b0; fmode3 = 1;

        #12;
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_fml_x", fml_x, 0);
        checkOutput("rst_fml_y", fml_y, 0);
        checkOutput("rst_rsp_found", rsp_found, 0);
        checkOutput("rst_rsp_y", rsp_y, 0);
        checkOutput("rst_rsp_iters", rsp_iters, 0);
        checkOutput("rst_req_ready3", req_ready3, 1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(32'h13, 0, 1'b1, cyc);
        checkOutput("match_latency", cyc, ITERS_13);
        checkOutput("match_found", rsp_found, 1);
        checkOutput("match_y", rsp_y, 19);
        checkOutput("match_iters", rsp_iters, ITERS_13);
        finishResp();

        applyStimulus(32'h55, 1, 1'b0, cyc);
        checkOutput("none_latency", cyc, 32);
        checkOutput("none_found", rsp_found, 0);
        checkOutput("none_y", rsp_y, 0);
        checkOutput("none_iters", rsp_iters, 32);
        finishResp();

        applyStimulus(32'hAA, 2, 1'b0, cyc);
        checkOutput("first_latency", cyc, 1);
        checkOutput("first_found", rsp_found, 1);
        checkOutput("first_y", rsp_y, 0);
        checkOutput("first_iters", rsp_iters, 1);
        req_valid = 1'b1;
        req_x     = 32'h5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_rsp_valid", rsp_valid, 1);
            checkOutput("hold_req_ready", req_ready, 0);
            checkOutput("hold_found", rsp_found, 1);
            checkOutput("hold_iters", rsp_iters, 1);
        end
        req_valid = 1'b0;
        finishResp();
        checkOutput("hold_fml_x", fml_x, 32'hAA);

        applyStimulus(X_TERM, 0, 1'b0, cyc);
        checkOutput("term_latency", cyc, 32);
        checkOutput("term_found", rsp_found, 1);
        checkOutput("term_y", rsp_y, Y_TERM);
        checkOutput("term_iters", rsp_iters, 32);
        finishResp();

        fmode     = 1;
        req_x     = 32'h13;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("pre_abort_y", fml_y, enc(7));
        rst_n = 1'b0;
        #1;
        checkOutput("abort_req_ready", req_ready, 1);
        checkOutput("abort_rsp_valid", rsp_valid, 0);
        checkOutput("abort_fml_y", fml_y, 0);
        checkOutput("abort_fml_x", fml_x, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(32'h13, 0, 1'b1, cyc);
        checkOutput("rerun_latency", cyc, ITERS_13);
        checkOutput("rerun_y", rsp_y, 19);
        checkOutput("rerun_iters", rsp_iters, ITERS_13);
        finishResp();

        applyStimulus3(1, cyc);
        checkOutput("lat3_none_latency", cyc, 96);
        checkOutput("lat3_none_found", rsp_found3, 0);
        checkOutput("lat3_none_iters", rsp_iters3, 32);
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        rsp_ready3 = 1'b0;
        checkOutput("lat3_hs_req_ready", req_ready3, 1);

        applyStimulus3(2, cyc);
        checkOutput("lat3_first_latency", cyc, 3);
        checkOutput("lat3_first_found", rsp_found3, 1);
        checkOutput("lat3_first_iters", rsp_iters3, 1);
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        rsp_ready3 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
